md_unit: RTL

- Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Sits beside the EX-stage ALU. EX issues start with an op code and two operands, stalls while busy, then reads hi/lo.
- Replaces single-cycle combinational mult/div. Adds:
  - a true signed/unsigned distinction,
  - defined divide-by-zero and overflow results,
  - a cancel (flush) path,
  - a handshake.

---
 rtl/md_unit.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit that owns the HI/LO register pair.
// MULT/MULTU use a radix-2 shift-add over a 2*WIDTH accumulator. DIV/DIVU use
// restoring division. Signed operations work on magnitudes, and FIX applies the
// signs at the end.
// Optional build macro MD_FAST_MUL_EN: multiplies take a single-cycle
// combinational product and go straight from IDLE to FIX. Divides are unchanged.
module md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             whi,
   input  logic             wlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int DW    = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Two's-complement negation of a WIDTH-bit value
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation of a 2*WIDTH-bit value
   function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] x);
      return ~x + {{(DW-1){1'b0}}, 1'b1};
   endfunction

   state_t             state_r, state_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [DW-1:0]      acc_r, acc_s;       // mul: {upper, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opnd_r, opnd_s;     // |multiplicand| or |divisor|
   logic [WIDTH-1:0]   a_r, a_s;           // original dividend, needed for divide by zero
   logic               is_div_r, is_div_s;
   logic               sa_r, sa_s;
   logic               sb_r, sb_s;
   logic               divz_r, divz_s;
   logic [WIDTH-1:0]   hi_r, hi_s;
   logic [WIDTH-1:0]   lo_r, lo_s;
   logic               busy_r, busy_s;
   logic               done_r, done_s;

   logic               a_neg_s, b_neg_s;
   logic [WIDTH-1:0]   abs_a_s, abs_b_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [DW-1:0]      mul_next_s;
   logic [WIDTH:0]     div_shift_s;
   logic [WIDTH-1:0]   div_diff_s;
   logic               div_ge_s;
   logic [DW-1:0]      div_next_s;
   logic [DW-1:0]      mul_res_s;
   logic [WIDTH-1:0]   quo_s, rem_s;
   logic [WIDTH-1:0]   res_hi_s, res_lo_s;
`ifdef MD_FAST_MUL_EN
   logic [DW-1:0]      fast_prod_s;
`endif

   assign a_neg_s = ~op[0] & a[WIDTH-1];
   assign b_neg_s = ~op[0] & b[WIDTH-1];
   assign abs_a_s = a_neg_s ? neg_w(a) : a;
   assign abs_b_s = b_neg_s ? neg_w(b) : b;

`ifdef MD_FAST_MUL_EN
   assign fast_prod_s = {ZERO_W, abs_a_s} * {ZERO_W, abs_b_s};
`endif

   // Shift-add step: add the multiplicand when the low multiplier bit is 1, then shift right.
   assign mul_sum_s  = {1'b0, acc_r[DW-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
   assign mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

   // Restoring step: shift the next dividend bit into the remainder and subtract if it fits.
   assign div_shift_s = {acc_r[DW-1:WIDTH], acc_r[WIDTH-1]};
   assign div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
   assign div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
   assign div_next_s  = div_ge_s ? {div_diff_s, acc_r[WIDTH-2:0], 1'b1}
                                 : {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};

   // Sign-corrected results from the magnitude accumulator
   assign mul_res_s = (sa_r ^ sb_r) ? neg_dw(acc_r) : acc_r;
   assign quo_s     = (sa_r ^ sb_r) ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
   assign rem_s     = sa_r ? neg_w(acc_r[DW-1:WIDTH]) : acc_r[DW-1:WIDTH];

   // Select the final HI/LO values; divide by zero has a fixed result
   always_comb begin
      res_hi_s = mul_res_s[DW-1:WIDTH];
      res_lo_s = mul_res_s[WIDTH-1:0];
      if (!is_div_r) begin
         res_hi_s = mul_res_s[DW-1:WIDTH];
         res_lo_s = mul_res_s[WIDTH-1:0];
      end else if (divz_r) begin
         res_hi_s = a_r;
         res_lo_s = ONES_W;
      end else begin
         res_hi_s = rem_s;
         res_lo_s = quo_s;
      end
   end

   // Next state, datapath updates, HI/LO writes and handshake outputs
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      acc_s    = acc_r;
      opnd_s   = opnd_r;
      a_s      = a_r;
      is_div_s = is_div_r;
      sa_s     = sa_r;
      sb_s     = sb_r;
      divz_s   = divz_r;
      hi_s     = hi_r;
      lo_s     = lo_r;
      done_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start && !flush) begin
               is_div_s = op[1];
               a_s      = a;
               sa_s     = a_neg_s;
               sb_s     = b_neg_s;
               divz_s   = (b == ZERO_W);
               cnt_s    = CNT_INIT;
               if (op[1]) begin
                  opnd_s  = abs_b_s;
                  acc_s   = {ZERO_W, abs_a_s};
                  state_s = CALC;
               end else begin
                  opnd_s  = abs_a_s;
`ifdef MD_FAST_MUL_EN
                  acc_s   = fast_prod_s;
                  state_s = FIX;
`else
                  acc_s   = {ZERO_W, abs_b_s};
                  state_s = CALC;
`endif
               end
            end else if (!start) begin
               // MTHI/MTLO only when idle with no start request
               if (whi) begin
                  hi_s = wdata;
               end else begin
                  hi_s = hi_r;
               end
               if (wlo) begin
                  lo_s = wdata;
               end else begin
                  lo_s = lo_r;
               end
            end else begin
               // start together with flush: request dropped, moves ignored
               state_s = IDLE;
            end
         end
         CALC: begin
            if (flush) begin
               state_s = IDLE;
            end else begin
               acc_s = is_div_r ? div_next_s : mul_next_s;
               cnt_s = cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_s = FIX;
               end else begin
                  state_s = CALC;
               end
            end
         end
         FIX: begin
            state_s = IDLE;
            if (!flush) begin
               hi_s   = res_hi_s;
               lo_s   = res_lo_s;
               done_s = 1'b1;
            end else begin
               done_s = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      busy_s = (state_s != IDLE);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Datapath, HI/LO and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r    <= {CNT_W{1'b0}};
         acc_r    <= {DW{1'b0}};
         opnd_r   <= ZERO_W;
         a_r      <= ZERO_W;
         is_div_r <= 1'b0;
         sa_r     <= 1'b0;
         sb_r     <= 1'b0;
         divz_r   <= 1'b0;
         hi_r     <= ZERO_W;
         lo_r     <= ZERO_W;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         cnt_r    <= cnt_s;
         acc_r    <= acc_s;
         opnd_r   <= opnd_s;
         a_r      <= a_s;
         is_div_r <= is_div_s;
         sa_r     <= sa_s;
         sb_r     <= sb_s;
         divz_r   <= divz_s;
         hi_r     <= hi_s;
         lo_r     <= lo_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule
